// File: rtl/nav_profile.sv
// nav_profile: forward/heading sequencer between the command processor and
// the PID. Runs heading phases with a watchdog, and forward moves with a
// ramped, saturating speed command. A move can end at the Nth qualified
// side opening, when the forward path closes, or on abort.
module nav_profile #(
    parameter int unsigned      SPD_W         = 11,
    parameter logic [SPD_W-1:0] MAX_FRWRD     = 11'h2A0,
    parameter logic [SPD_W-1:0] MIN_FRWRD     = 11'h0D0,
    parameter logic [5:0]       FRWRD_INC     = 6'h18,
    parameter int unsigned      DEC_NORM_SHFT = 1,
    parameter int unsigned      DEC_FAST_SHFT = 3,
    parameter logic [SPD_W-1:0] FUSION_THR    = MAX_FRWRD / 2,
    parameter int unsigned      OPN_W         = 3,
    parameter int unsigned      HDNG_TMO      = 32'd16777216
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt_hdng,
    input  logic             strt_mv,
    input  logic             stp_lft,
    input  logic             stp_rght,
    input  logic [OPN_W-1:0] opn_cnt,
    input  logic             abort,
    input  logic             hdng_rdy,
    input  logic             at_hdng,
    input  logic             lft_opn,
    input  logic             rght_opn,
    input  logic             frwrd_opn,
    output logic [SPD_W-1:0] frwrd_spd,
    output logic             moving,
    output logic             en_fusion,
    output logic             mv_cmplt,
    output logic             hdng_err
);

    localparam int unsigned      WD_W      = (HDNG_TMO > 1) ? $clog2(HDNG_TMO) : 1;
    localparam bit               WD_EN     = (HDNG_TMO != 0);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(HDNG_TMO - 1);
    localparam logic [SPD_W-1:0] INC_EXT   = SPD_W'(FRWRD_INC);
    localparam logic [SPD_W-1:0] STEP_NORM = INC_EXT << DEC_NORM_SHFT;
    localparam logic [SPD_W-1:0] STEP_FAST = INC_EXT << DEC_FAST_SHFT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADING,
        S_MOVING,
        S_DEC_NORM,
        S_DEC_FAST
    } state_t;

    state_t           state;
    logic [OPN_W-1:0] opn_tgt;
    logic [OPN_W-1:0] opn_seen;
    logic [WD_W-1:0]  wd;
    logic             lft_ff;
    logic             rght_ff;

    logic             lft_rise;
    logic             rght_rise;
    logic             qual_evt;
    logic [SPD_W:0]   acc_sum;
    logic [SPD_W-1:0] acc_spd;
    logic [SPD_W-1:0] dec_norm_spd;
    logic [SPD_W-1:0] dec_fast_spd;
    logic [OPN_W:0]   seen_nxt;
    logic [OPN_W-1:0] opn_tgt_ld;

    // A simultaneous left and right rise is a single qualified event
    assign lft_rise  = lft_opn & ~lft_ff;
    assign rght_rise = rght_opn & ~rght_ff;
    assign qual_evt  = (lft_rise & stp_lft) | (rght_rise & stp_rght);

    // Extra carry bit so the saturation compare cannot wrap
    assign acc_sum = {1'b0, frwrd_spd} + {1'b0, INC_EXT};
    assign acc_spd = (acc_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : acc_sum[SPD_W-1:0];

    assign dec_norm_spd = (frwrd_spd > STEP_NORM) ? (frwrd_spd - STEP_NORM) : '0;
    assign dec_fast_spd = (frwrd_spd > STEP_FAST) ? (frwrd_spd - STEP_FAST) : '0;

    assign seen_nxt   = {1'b0, opn_seen} + (OPN_W + 1)'(1);
    assign opn_tgt_ld = (opn_cnt == '0) ? OPN_W'(1) : opn_cnt;

    assign en_fusion = (frwrd_spd > FUSION_THR);

    // Delay the IR opening inputs one clock for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_ff  <= 1'b0;
            rght_ff <= 1'b0;
        end else begin
            lft_ff  <= lft_opn;
            rght_ff <= rght_opn;
        end
    end

    // Phase sequencer with speed ramp, opening counter and heading watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            frwrd_spd <= '0;
            opn_tgt   <= '0;
            opn_seen  <= '0;
            wd        <= '0;
            moving    <= 1'b0;
            mv_cmplt  <= 1'b0;
            hdng_err  <= 1'b0;
        end else begin
            mv_cmplt <= 1'b0;
            hdng_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (strt_hdng) begin
                        state  <= S_HEADING;
                        wd     <= '0;
                        moving <= 1'b1;
                    end else if (strt_mv) begin
                        state     <= S_MOVING;
                        frwrd_spd <= MIN_FRWRD;
                        opn_tgt   <= opn_tgt_ld;
                        opn_seen  <= '0;
                        moving    <= 1'b1;
                    end
                end
                S_HEADING: begin
                    if (abort || at_hdng) begin
                        state    <= S_IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                    end else if (WD_EN && (wd == WD_LAST)) begin
                        state    <= S_IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                        hdng_err <= 1'b1;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_MOVING: begin
                    if (!frwrd_opn || abort) begin
                        state <= S_DEC_FAST;
                    end else if (qual_evt) begin
                        opn_seen <= opn_seen + OPN_W'(1);
                        if (seen_nxt == {1'b0, opn_tgt})
                            state <= S_DEC_NORM;
                    end else if (hdng_rdy) begin
                        frwrd_spd <= acc_spd;
                    end
                end
                S_DEC_NORM: begin
                    if (frwrd_spd == '0) begin
                        state    <= S_IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                    end else if (abort || !frwrd_opn) begin
                        state <= S_DEC_FAST;
                    end else if (hdng_rdy) begin
                        frwrd_spd <= dec_norm_spd;
                    end
                end
                S_DEC_FAST: begin
                    if (frwrd_spd == '0) begin
                        state    <= S_IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                    end else if (hdng_rdy) begin
                        frwrd_spd <= dec_fast_spd;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    moving <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nav_profile.sv
// tb_nav_profile: self-checking bench for nav_profile with a short heading
// watchdog. Speed expectations come from tables and a queue scoreboard;
// completion and watchdog pulses are counted by a monitor.
module tb_nav_profile;

    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_hdng = 1'b0;
    logic        strt_mv = 1'b0;
    logic        stp_lft = 1'b0;
    logic        stp_rght = 1'b0;
    logic [2:0]  opn_cnt = 3'd0;
    logic        abort = 1'b0;
    logic        hdng_rdy = 1'b0;
    logic        at_hdng = 1'b0;
    logic        lft_opn = 1'b0;
    logic        rght_opn = 1'b0;
    logic        frwrd_opn = 1'b0;
    logic [10:0] frwrd_spd;
    logic        moving;
    logic        en_fusion;
    logic        mv_cmplt;
    logic        hdng_err;

    nav_profile #(.HDNG_TMO(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .opn_cnt   (opn_cnt),
        .abort     (abort),
        .hdng_rdy  (hdng_rdy),
        .at_hdng   (at_hdng),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .frwrd_opn (frwrd_opn),
        .frwrd_spd (frwrd_spd),
        .moving    (moving),
        .en_fusion (en_fusion),
        .mv_cmplt  (mv_cmplt),
        .hdng_err  (hdng_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] spd;
        logic        fus;
    } exp_t;

    exp_t acc_tbl[21];
    exp_t fast_tbl[4];
    exp_t norm_tbl[14];
    exp_t abrt_tbl[3];
    exp_t sb_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cmplt_cnt = 0;
    int err_cnt = 0;

    // Count completion and watchdog pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (mv_cmplt === 1'b1) cmplt_cnt++;
        if (hdng_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One hdng_rdy strobe followed by three quiet clocks
    task automatic strobe(input exp_t e, input string nm);
        exp_t got;
        hdng_rdy = 1'b1;
        sb_q.push_back(e);
        step();
        hdng_rdy = 1'b0;
        if (sb_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk({nm, "_spd"}, 32'(frwrd_spd), 32'(got.spd));
            chk({nm, "_fus"}, 32'(en_fusion), 32'(got.fus));
        end
        step(3);
    endtask

    task automatic start_move(input logic [2:0] cnt);
        opn_cnt = cnt;
        strt_mv = 1'b1;
        step();
        strt_mv = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int c0;
        int e0;
        int n;

        acc_tbl = '{
            '{11'h0E8, 1'b0}, '{11'h100, 1'b0}, '{11'h118, 1'b0}, '{11'h130, 1'b0},
            '{11'h148, 1'b0}, '{11'h160, 1'b1}, '{11'h178, 1'b1}, '{11'h190, 1'b1},
            '{11'h1A8, 1'b1}, '{11'h1C0, 1'b1}, '{11'h1D8, 1'b1}, '{11'h1F0, 1'b1},
            '{11'h208, 1'b1}, '{11'h220, 1'b1}, '{11'h238, 1'b1}, '{11'h250, 1'b1},
            '{11'h268, 1'b1}, '{11'h280, 1'b1}, '{11'h298, 1'b1}, '{11'h2A0, 1'b1},
            '{11'h2A0, 1'b1}
        };
        fast_tbl = '{'{11'h1E0, 1'b1}, '{11'h120, 1'b0}, '{11'h060, 1'b0}, '{11'h000, 1'b0}};
        norm_tbl = '{
            '{11'h270, 1'b1}, '{11'h240, 1'b1}, '{11'h210, 1'b1}, '{11'h1E0, 1'b1},
            '{11'h1B0, 1'b1}, '{11'h180, 1'b1}, '{11'h150, 1'b0}, '{11'h120, 1'b0},
            '{11'h0F0, 1'b0}, '{11'h0C0, 1'b0}, '{11'h090, 1'b0}, '{11'h060, 1'b0},
            '{11'h030, 1'b0}, '{11'h000, 1'b0}
        };
        abrt_tbl = '{'{11'h0D0, 1'b0}, '{11'h010, 1'b0}, '{11'h000, 1'b0}};

        // Reset state
        step(2);
        chk("rst_spd", 32'(frwrd_spd), 32'h0);
        chk("rst_moving", 32'(moving), 32'h0);
        chk("rst_fus", 32'(en_fusion), 32'h0);
        chk("rst_cmplt", 32'(mv_cmplt), 32'h0);
        chk("rst_err", 32'(hdng_err), 32'h0);
        rst_n = 1'b1;
        step();

        // Accelerate from MIN to saturation; a strt_hdng mid-move is ignored
        frwrd_opn = 1'b1;
        start_move(3'd0);
        chk("t1_start_spd", 32'(frwrd_spd), 32'h0D0);
        chk("t1_start_moving", 32'(moving), 32'h1);
        step(3);
        for (int i = 0; i < 21; i++) begin
            strt_hdng = (i == 3);
            strobe(acc_tbl[i], $sformatf("t1_acc%0d", i));
        end
        strt_hdng = 1'b0;

        // Forward path closes: fast decel to zero and one completion
        c0 = cmplt_cnt;
        e0 = err_cnt;
        frwrd_opn = 1'b0;
        step();
        chk("t2_enter_spd", 32'(frwrd_spd), 32'h2A0);
        for (int i = 0; i < 4; i++) strobe(fast_tbl[i], $sformatf("t2_fast%0d", i));
        chk("t2_moving", 32'(moving), 32'h0);
        chk("t2_cmplt_cnt", 32'(cmplt_cnt - c0), 32'h1);
        chk("t2_err_cnt", 32'(err_cnt - e0), 32'h0);
        frwrd_opn = 1'b1;

        // Stop at third qualified opening; held level and simultaneous rise count once
        stp_lft = 1'b1;
        stp_rght = 1'b1;
        start_move(3'd3);
        step(3);
        for (int i = 0; i < 20; i++) strobe(acc_tbl[i], $sformatf("t3_acc%0d", i));
        c0 = cmplt_cnt;
        lft_opn = 1'b1;
        step(3);
        lft_opn = 1'b0;
        step();
        strobe('{11'h2A0, 1'b1}, "t3_after_open1");
        lft_opn = 1'b1;
        rght_opn = 1'b1;
        step();
        lft_opn = 1'b0;
        rght_opn = 1'b0;
        step();
        strobe('{11'h2A0, 1'b1}, "t3_after_open2");
        lft_opn = 1'b1;
        step();
        lft_opn = 1'b0;
        step();
        for (int i = 0; i < 14; i++) strobe(norm_tbl[i], $sformatf("t3_norm%0d", i));
        chk("t3_moving", 32'(moving), 32'h0);
        chk("t3_cmplt_cnt", 32'(cmplt_cnt - c0), 32'h1);

        // Heading watchdog expiry after TMO clocks
        e0 = err_cnt;
        strt_hdng = 1'b1;
        step();
        strt_hdng = 1'b0;
        chk("t4_hdng_moving", 32'(moving), 32'h1);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (mv_cmplt === 1'b1) begin
                n = k;
                break;
            end
        end
        chk("t4_wd_cycles", 32'(n), 32'(TMO));
        chk("t4_wd_err", 32'(hdng_err), 32'h1);
        chk("t4_wd_moving", 32'(moving), 32'h0);
        step();
        chk("t4_cmplt_width", 32'(mv_cmplt), 32'h0);
        chk("t4_err_width", 32'(hdng_err), 32'h0);

        // Heading reached at clock 10: completion without error
        strt_hdng = 1'b1;
        step();
        strt_hdng = 1'b0;
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            if (k == 10) at_hdng = 1'b1;
            step();
            if (mv_cmplt === 1'b1) begin
                n = k;
                break;
            end
        end
        at_hdng = 1'b0;
        chk("t4_at_cycles", 32'(n), 32'd10);
        chk("t4_at_err", 32'(hdng_err), 32'h0);
        chk("t4_err_cnt", 32'(err_cnt - e0), 32'h1);
        chk("t4_spd_untouched", 32'(frwrd_spd), 32'h0);

        // Abort ignored in IDLE; strt_mv with abort starts a move, abort not kept
        abort = 1'b1;
        step();
        chk("t5_idle_abort", 32'(moving), 32'h0);
        strt_mv = 1'b1;
        step();
        strt_mv = 1'b0;
        abort = 1'b0;
        chk("t5_mv_abort_spd", 32'(frwrd_spd), 32'h0D0);
        step();
        chk("t5_abort_not_kept", 32'(moving), 32'h1);
        step(2);
        c0 = cmplt_cnt;
        for (int i = 0; i < 8; i++) strobe(acc_tbl[i], $sformatf("t5_acc%0d", i));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_spd", 32'(frwrd_spd), 32'h190);
        for (int i = 0; i < 3; i++) strobe(abrt_tbl[i], $sformatf("t5_fast%0d", i));
        chk("t5_moving", 32'(moving), 32'h0);
        chk("t5_cmplt_cnt", 32'(cmplt_cnt - c0), 32'h1);

        // Abort during heading: immediate completion, no error
        strt_hdng = 1'b1;
        step();
        strt_hdng = 1'b0;
        step(5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_hdng_cmplt", 32'(mv_cmplt), 32'h1);
        chk("t5_hdng_err", 32'(hdng_err), 32'h0);
        chk("t5_hdng_moving", 32'(moving), 32'h0);

        // opn_cnt 0 stops at first left opening; unenabled right rise is ignored
        stp_lft = 1'b1;
        stp_rght = 1'b0;
        start_move(3'd0);
        step(3);
        for (int i = 0; i < 4; i++) strobe(acc_tbl[i], $sformatf("t6_acc%0d", i));
        rght_opn = 1'b1;
        step();
        rght_opn = 1'b0;
        step();
        strobe(acc_tbl[4], "t6_rght_ignored");
        lft_opn = 1'b1;
        step();
        lft_opn = 1'b0;
        step();
        strobe('{11'h118, 1'b0}, "t6_norm0");

        // Asynchronous reset mid-decel
        c0 = cmplt_cnt;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_spd", 32'(frwrd_spd), 32'h0);
        chk("t6_arst_moving", 32'(moving), 32'h0);
        chk("t6_arst_fus", 32'(en_fusion), 32'h0);
        chk("t6_arst_cmplt", 32'(mv_cmplt), 32'h0);
        step(2);
        chk("t6_arst_no_cmplt", 32'(cmplt_cnt - c0), 32'h0);
        rst_n = 1'b1;
        step();

        // strt_hdng has priority over strt_mv
        strt_mv = 1'b1;
        strt_hdng = 1'b1;
        step();
        strt_mv = 1'b0;
        strt_hdng = 1'b0;
        chk("t6_prio_moving", 32'(moving), 32'h1);
        chk("t6_prio_spd", 32'(frwrd_spd), 32'h0);
        at_hdng = 1'b1;
        step();
        at_hdng = 1'b0;
        chk("t6_prio_cmplt", 32'(mv_cmplt), 32'h1);
        chk("t6_prio_idle", 32'(moving), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
